// File: rtl/vctcxo_dac_ramp.sv
// vctcxo_dac_ramp
//   Slew-limited code generator feeding the LTC2630 SPI DAC driver. A target
//   code is accepted over valid/ready and dac_data walks toward it in steps of
//   at most STEP_MAX, one update every INTERVAL cycles, so the VCTCXO tuning
//   voltage never jumps and each code change maps to one SPI frame.
//
// Ports:
//   clk          : single rising-edge clock
//   rst_n        : synchronous active-low reset
//   target_valid : target is valid this cycle
//   target[15:0] : requested DAC code
//   target_ready : target can be accepted (low only during the STEP cycle)
//   dac_data     : registered code to the SPI driver data input
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse when dac_data reaches the latched target
module vctcxo_dac_ramp #(
   parameter logic [15:0] STEP_MAX  = 16'd64,
   parameter int          INTERVAL  = 2000,
   parameter logic [15:0] INIT_CODE = 16'h8000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        target_valid,
   input  logic [15:0] target,
   output logic        target_ready,
   output logic [15:0] dac_data,
   output logic        busy,
   output logic        done
);

   localparam int CNT_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INTERVAL - 2);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        tgt_q, tgt_d;
   logic [15:0]        dac_q, dac_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic               accept;
   logic signed [16:0] diff;
   logic [16:0]        mag;

   assign accept = target_valid && ready_q;

   // Both operands are zero-extended, so the 17-bit result carries the sign
   // of (tgt - dac) and its magnitude never exceeds 65535.
   assign diff = $signed({1'b0, tgt_q}) - $signed({1'b0, dac_q});
   assign mag  = diff[16] ? 17'(-diff) : 17'(diff);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      dac_d   = dac_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tgt_d = target;
               if (target == dac_q) done_d  = 1'b1;
               else                 state_d = S_STEP;
            end
         end
         S_STEP: begin
            // A full step is only taken when |diff| > STEP_MAX, so the
            // 16-bit add/subtract below cannot wrap past a rail.
            if (mag <= {1'b0, STEP_MAX}) begin
               dac_d   = tgt_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               dac_d   = diff[16] ? (dac_q - STEP_MAX) : (dac_q + STEP_MAX);
               cnt_d   = CNT_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Retarget only moves tgt; cadence and current code are kept.
            if (accept) tgt_d = target;
            if (cnt_q == '0) state_d = S_STEP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d != S_STEP);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tgt_q   <= INIT_CODE;
         dac_q   <= INIT_CODE;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         dac_q   <= dac_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign target_ready = ready_q;
   assign dac_data     = dac_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_vctcxo_dac_ramp.sv
// Scoreboard bench for vctcxo_dac_ramp. Stimulus pushes expected output
// events (dac_data change and/or done pulse) into a queue; the monitor pops
// and compares whenever dac_data changes or done is high.
module tb_vctcxo_dac_ramp;

   localparam logic [15:0] STEP = 16'd64;
   localparam int          IVL  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        target_valid = 1'b0;
   logic [15:0] target = '0;
   logic        target_ready;
   logic [15:0] dac_data;
   logic        busy;
   logic        done;

   typedef struct {
      logic [15:0] val;
      logic        dn;
      logic        bsy;
      int          cyc;   // absolute cycle the event must appear in, -1 = any
   } ev_t;

   ev_t         q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic [15:0] prev_dac = '0;
   logic [15:0] cur;      // bench's notion of the current code
   int          acc;

   vctcxo_dac_ramp #(.STEP_MAX(STEP), .INTERVAL(IVL), .INIT_CODE(16'h8000)) dut (
      .clk(clk), .rst_n(rst_n), .target_valid(target_valid), .target(target),
      .target_ready(target_ready), .dac_data(dac_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor
   always @(negedge clk) begin
      if (mon_en && (dac_data !== prev_dac || done === 1'b1)) begin
         checks = checks + 1;
         if (q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_event cyc=%0d dac=%h done=%b", cyc, dac_data, done);
         end else begin
            ev_t e;
            e = q.pop_front();
            if (dac_data !== e.val || done !== e.dn || busy !== e.bsy ||
                (e.cyc >= 0 && cyc != e.cyc)) begin
               errors = errors + 1;
               $display("FAIL event got dac=%h done=%b busy=%b cyc=%0d want dac=%h done=%b busy=%b cyc=%0d",
                        dac_data, done, busy, cyc, e.val, e.dn, e.bsy, e.cyc);
            end
         end
      end
      prev_dac = dac_data;
   end

   task automatic push(input logic [15:0] v, input logic dn, input logic bsy, input int c);
      ev_t e;
      e.val = v; e.dn = dn; e.bsy = bsy; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One-cycle valid pulse; acc = edge index of the accepting edge.
   task automatic issue(input logic [15:0] t);
      @(negedge clk);
      target_valid = 1'b1;
      target = t;
      @(posedge clk);
      #1;
      acc = cyc;
      target_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain_timeout pending=%0d want=0", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Bulk repositioning: expected steps generated from a simple walk.
   task automatic move_to(input logic [15:0] t);
      int k;
      issue(t);
      k = 0;
      while ((t > cur ? t - cur : cur - t) > STEP) begin
         cur = (t > cur) ? cur + STEP : cur - STEP;
         push(cur, 1'b0, 1'b1, acc + 1 + k * IVL);
         k++;
      end
      cur = t;
      push(t, 1'b1, 1'b0, acc + 1 + k * IVL);
      drain(20000);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // 1. Reset held 3 cycles with valid high
      target_valid = 1'b1;
      target = 16'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dac", {16'h0, dac_data}, 32'h8000);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_ready", {31'h0, target_ready}, 32'h1);
      target_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_no_accept", {15'h0, busy, dac_data}, 32'h8000);
      prev_dac = dac_data;
      mon_en = 1'b1;

      // 2. Upward ramp 0x8000 -> 0x8100
      issue(16'h8100);
      push(16'h8040, 1'b0, 1'b1, acc + 1);
      push(16'h8080, 1'b0, 1'b1, acc + 9);
      push(16'h80C0, 1'b0, 1'b1, acc + 17);
      push(16'h8100, 1'b1, 1'b0, acc + 25);
      @(negedge clk);
      chk("step_ready_low", {31'h0, target_ready}, 32'h0);
      chk("step_busy_high", {31'h0, busy}, 32'h1);
      drain(100);

      // 3. Small step then equal target (start from mid-scale)
      push(16'h8000, 1'b0, 1'b0, -1);
      pulse_reset();
      issue(16'h7FF0);
      push(16'h7FF0, 1'b1, 1'b0, acc + 1);
      drain(50);
      issue(16'h7FF0);
      push(16'h7FF0, 1'b1, 1'b0, -1);
      drain(50);
      chk("equal_busy", {31'h0, busy}, 32'h0);

      // 4. Rails
      cur = 16'h7FF0;
      move_to(16'h0020);
      issue(16'h0000);
      push(16'h0000, 1'b1, 1'b0, acc + 1);
      drain(50);
      cur = 16'h0000;
      move_to(16'hFF00);
      issue(16'hFFFF);
      push(16'hFF40, 1'b0, 1'b1, acc + 1);
      push(16'hFF80, 1'b0, 1'b1, acc + 9);
      push(16'hFFC0, 1'b0, 1'b1, acc + 17);
      push(16'hFFFF, 1'b1, 1'b0, acc + 25);
      drain(100);

      // 5. Retarget in WAIT
      push(16'h8000, 1'b0, 1'b0, -1);
      pulse_reset();
      issue(16'h8200);
      push(16'h8040, 1'b0, 1'b1, acc + 1);
      push(16'h8000, 1'b1, 1'b0, acc + 9);
      repeat (3) @(negedge clk);
      issue(16'h8000);
      drain(100);
      issue(16'h8200);
      push(16'h8040, 1'b0, 1'b1, acc + 1);
      push(16'h8040, 1'b1, 1'b0, acc + 9);
      repeat (3) @(negedge clk);
      issue(16'h8040);
      drain(100);

      // 6. Reset mid-ramp
      issue(16'h9000);
      push(16'h8080, 1'b0, 1'b1, acc + 1);
      drain(20);
      push(16'h8000, 1'b0, 1'b0, -1);
      pulse_reset();
      @(negedge clk);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_ready", {31'h0, target_ready}, 32'h1);
      drain(20);
      repeat (IVL * 2) @(negedge clk);
      issue(16'h8010);
      push(16'h8010, 1'b1, 1'b0, acc + 1);
      drain(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
